// File: rtl/adder_pipe_acc.sv
// Pipelined unsigned adder with valid/ready flow control and a running accumulator.
// A single global stall freezes every slot whenever the last one holds an untaken result.
module adder_pipe_acc #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             acc_ovf
);

    localparam int SW = WIDTH + 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [SW-1:0]     sum_q [STAGES];
    logic [SW-1:0]     sum_d [STAGES];
    logic [SW-1:0]     acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              advance;
    logic              accept;
    logic [SW-1:0]     acc_base;
    logic [SW:0]       acc_full;
    logic [SW-1:0]     result;

    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign accept   = in_valid && advance;
    assign in_ready = advance;

    // Clear is applied before the accumulate, so clr + accept yields plain a.
    always_comb begin
        acc_base = clr ? '0 : acc_q;
        acc_full = {1'b0, acc_base} + {2'b00, a};
        result   = mode ? acc_full[SW-1:0] : ({1'b0, a} + {1'b0, b});

        // NOTE: every comb output gets a default first so no latch is inferred.
        acc_d = acc_base;
        ovf_d = clr ? 1'b0 : ovf_q;
        if (accept && mode) begin
            acc_d = acc_full[SW-1:0];
            ovf_d = ovf_d | acc_full[SW];
        end
    end

    always_comb begin
        vld_d = vld_q;
        sum_d = sum_q;
        if (advance) begin
            vld_d[0] = accept;
            sum_d[0] = accept ? result : '0;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                sum_d[i] = sum_q[i-1];
            end
        end
    end

    // NOTE: the sum slots are reset too, so sum reads 0 during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= sum_d[i];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign acc_ovf   = ovf_q;

endmodule
